// File: rtl/reg_file_mb.sv
// Register file with two combinational read ports, one write port and a
// one-entry pending buffer that holds write-back while a multiply is busy.
module reg_file_mb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int MUL_LAT = 32,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WN,
    input  logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] RN1,
    input  logic [ADDR_W-1:0] RN2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              mul_start,
    output logic              mul_busy,
    output logic              wr_stall
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MUL_LAT);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic wr_valid, accept;

    assign mul_busy = (cnt != '0);
    assign wr_valid = RegWrite && (WN != '0);
    assign accept   = wr_valid && !pend_valid;
    assign wr_stall = wr_valid && pend_valid;

    // A start while busy is ignored, so the countdown is never restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (mul_busy)
            cnt <= cnt - CNT_W'(1);
        else if (mul_start)
            cnt <= LAT;
    end

    // Accept and drain are mutually exclusive (pend_valid 0 vs 1), so the
    // array sees at most one write per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            if (accept && !mul_busy) begin
                regs[WN] <= WD;
            end else if (pend_valid && !mul_busy) begin
                regs[pend_addr] <= pend_data;
                pend_valid      <= 1'b0;
            end
            if (accept && mul_busy) begin
                pend_valid <= 1'b1;
                pend_addr  <= WN;
                pend_data  <= WD;
            end
        end
    end

    // Later assignments take priority: r0, then the accepted write, then pending.
    always_comb begin
        RD1 = regs[RN1];
        if (BYPASS != 0 && pend_valid && pend_addr == RN1) RD1 = pend_data;
        if (BYPASS != 0 && accept && WN == RN1)            RD1 = WD;
        if (RN1 == '0)                                     RD1 = '0;
    end

    always_comb begin
        RD2 = regs[RN2];
        if (BYPASS != 0 && pend_valid && pend_addr == RN2) RD2 = pend_data;
        if (BYPASS != 0 && accept && WN == RN2)            RD2 = WD;
        if (RN2 == '0)                                     RD2 = '0;
    end

endmodule

// File: tb/tb_reg_file_mb.sv
// Scoreboard bench: expectations are queued as stimulus is driven and
// compared at the following negedge against a bypass and a no-bypass copy.
module tb_reg_file_mb;

    localparam int SEL_RD1 = 0, SEL_RD2 = 1, SEL_BUSY = 2, SEL_STALL = 3,
                   SEL_NB1 = 4, SEL_NB2 = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite, mul_start;
    logic [4:0]  WN, RN1, RN2;
    logic [31:0] WD;
    logic [31:0] RD1, RD2, nb_RD1, nb_RD2;
    logic        mul_busy, wr_stall, nb_busy, nb_stall;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    reg_file_mb #(.DATA_W(32), .ADDR_W(5), .MUL_LAT(4), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WN(WN), .WD(WD),
        .RN1(RN1), .RN2(RN2), .RD1(RD1), .RD2(RD2),
        .mul_start(mul_start), .mul_busy(mul_busy), .wr_stall(wr_stall)
    );

    reg_file_mb #(.DATA_W(32), .ADDR_W(5), .MUL_LAT(4), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WN(WN), .WD(WD),
        .RN1(RN1), .RN2(RN2), .RD1(nb_RD1), .RD2(nb_RD2),
        .mul_start(mul_start), .mul_busy(nb_busy), .wr_stall(nb_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SEL_RD1:   return RD1;
            SEL_RD2:   return RD2;
            SEL_BUSY:  return {31'd0, mul_busy};
            SEL_STALL: return {31'd0, wr_stall};
            SEL_NB1:   return nb_RD1;
            default:   return nb_RD2;
        endcase
    endfunction

    task automatic ex(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = v;
        q.push_back(e);
    endtask

    // Compare this cycle's queued expectations, then advance past the edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
        @(posedge clk);
        #1;
        mul_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; RegWrite = 1'b0; WN = '0; WD = '0;
        RN1 = '0; RN2 = '0; mul_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ex("rst_busy", SEL_BUSY, 0); ex("rst_stall", SEL_STALL, 0);
        cyc();
        rst_n = 1'b1;

        // activity, then asynchronous reset mid-cycle
        RegWrite = 1'b1; WN = 5'd1; WD = 32'hDEAD; mul_start = 1'b1;
        cyc();
        WN = 5'd2; WD = 32'hBEEF;
        cyc();
        RegWrite = 1'b0; RN1 = 5'd2;
        #2 rst_n = 1'b0;
        ex("mid_rst_busy", SEL_BUSY, 0); ex("mid_rst_stall", SEL_STALL, 0);
        ex("mid_rst_r2", SEL_RD1, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            RN1 = 5'(i); RN2 = 5'(i);
            ex($sformatf("rst_rd1_r%0d", i), SEL_RD1, 0);
            ex($sformatf("rst_nb2_r%0d", i), SEL_NB2, 0);
            ex("rst_idle_busy", SEL_BUSY, 0);
            ex("rst_idle_stall", SEL_STALL, 0);
            cyc();
        end

        // r0 is hardwired
        RegWrite = 1'b1; WN = 5'd0; WD = 32'hFFFF_FFFF; RN1 = 5'd0; RN2 = 5'd0;
        ex("r0_rd1", SEL_RD1, 0); ex("r0_rd2", SEL_RD2, 0); ex("r0_stall", SEL_STALL, 0);
        cyc();
        RegWrite = 1'b0;
        ex("r0_after", SEL_RD1, 0); ex("r0_after_nb", SEL_NB1, 0);
        cyc();

        // idle write with and without bypass
        RegWrite = 1'b1; WN = 5'd5; WD = 32'h1234; RN1 = 5'd5;
        ex("byp_same", SEL_RD1, 32'h1234); ex("nobyp_same", SEL_NB1, 0);
        cyc();
        RegWrite = 1'b0;
        ex("byp_next", SEL_RD1, 32'h1234); ex("nobyp_next", SEL_NB1, 32'h1234);
        cyc();

        // write during busy goes to pending, drains one edge after busy falls
        mul_start = 1'b1; ex("mb_pre_busy", SEL_BUSY, 0);
        cyc();
        RegWrite = 1'b1; WN = 5'd7; WD = 32'hAA; RN2 = 5'd7;
        ex("mb_fwd", SEL_RD2, 32'hAA); ex("mb_fwd_nb", SEL_NB2, 0);
        ex("mb_busy1", SEL_BUSY, 1); ex("mb_stall", SEL_STALL, 0);
        cyc();
        RegWrite = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            ex("mb_pend_rd", SEL_RD2, 32'hAA); ex("mb_pend_arr", SEL_NB2, 0);
            ex($sformatf("mb_busy%0d", i), SEL_BUSY, 1);
            cyc();
        end
        ex("mb_fall", SEL_BUSY, 0); ex("mb_pre_drain", SEL_NB2, 0);
        ex("mb_pre_drain_byp", SEL_RD2, 32'hAA); ex("mb_nostall", SEL_STALL, 0);
        cyc();
        ex("mb_drained_nb", SEL_NB2, 32'hAA); ex("mb_drained", SEL_RD2, 32'hAA);
        cyc();

        // stall while pending is occupied, up to and including the drain cycle
        mul_start = 1'b1;
        cyc();
        RegWrite = 1'b1; WN = 5'd3; WD = 32'd1; RN1 = 5'd3; RN2 = 5'd4;
        ex("st_first", SEL_STALL, 0); ex("st_fwd3", SEL_RD1, 1);
        cyc();
        WN = 5'd4; WD = 32'd2;
        for (int i = 0; i < 4; i++) begin
            ex($sformatf("st_stall%0d", i), SEL_STALL, 1);
            ex("st_nofwd4", SEL_RD2, 0);
            ex("st_pend3", SEL_RD1, 1);
            ex("st_arr3", SEL_NB1, 0);
            cyc();
        end
        ex("st_accept", SEL_STALL, 0); ex("st_fwd4", SEL_RD2, 2); ex("st_arr4_pre", SEL_NB2, 0);
        ex("st_arr3_drained", SEL_NB1, 1);
        cyc();
        RegWrite = 1'b0;
        ex("st_final3", SEL_NB1, 1); ex("st_final4", SEL_NB2, 2); ex("st_final4_byp", SEL_RD2, 2);
        cyc();

        // a second start while busy must not reload the count
        mul_start = 1'b1;
        cyc();
        mul_start = 1'b1;
        ex("rs_busy1", SEL_BUSY, 1);
        cyc();
        for (int i = 2; i <= 4; i++) begin
            ex($sformatf("rs_busy%0d", i), SEL_BUSY, 1);
            cyc();
        end
        ex("rs_fall", SEL_BUSY, 0);
        cyc();
        ex("rs_idle", SEL_BUSY, 0);
        cyc();

        // reset with counter=2 and a pending entry discards both
        mul_start = 1'b1;
        cyc();
        RegWrite = 1'b1; WN = 5'd9; WD = 32'h55; RN2 = 5'd9;
        ex("rb_fwd9", SEL_RD2, 32'h55); ex("rb_busy", SEL_BUSY, 1);
        cyc();
        WN = 5'd0; WD = 32'hFFFF_FFFF;
        ex("rb_r0_nostall", SEL_STALL, 0); ex("rb_pend9", SEL_RD2, 32'h55);
        ex("rb_arr9", SEL_NB2, 0);
        cyc();
        RegWrite = 1'b0; RN1 = 5'd7;
        #2 rst_n = 1'b0;
        ex("rb_busy_rst", SEL_BUSY, 0); ex("rb_stall_rst", SEL_STALL, 0);
        ex("rb_r9_rst", SEL_RD2, 0); ex("rb_r7_rst", SEL_RD1, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ex($sformatf("rb_nodrain%0d", i), SEL_NB2, 0);
            ex("rb_nodrain_byp", SEL_RD2, 0);
            ex("rb_idle_busy", SEL_BUSY, 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_mb.md
# reg_file_mb

Parametrised register file for the 5-stage pipelined CPU with a multiplier-busy write-hold mechanism. While a multicycle multiply runs, write-back is captured in a one-entry pending buffer instead of being dropped. That buffer drains automatically when the multiplier finishes. The block sits between the ID stage (two combinational read ports) and the WB stage (one write port), and reports `wr_stall` so the hazard unit can freeze the pipeline.

## Interface
- `DATA_W`, default 32, register width in bits.
- `ADDR_W`, default 5, register index width; the array holds 2**ADDR_W registers, and register 0 is hardwired to zero.
- `MUL_LAT`, default 32, number of busy cycles per multiply (at least 1).
- `BYPASS`, default 1. When 1, reads forward the in-flight write and the pending entry; when 0, reads return array contents only (register 0 still reads 0).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RegWrite`  in  1  write request from WB.
- `WN`  in  ADDR_W  write register number.
- `WD`  in  DATA_W  write data.
- `RN1`, `RN2`  in  ADDR_W  read register numbers (rs, rt).
- `RD1`, `RD2`  out  DATA_W  read data, combinational.
- `mul_start`  in  1  one-cycle pulse that starts a multiply.
- `mul_busy`  out  1  high while the multiply countdown is non-zero.
- `wr_stall`  out  1  the write presented this cycle is not accepted; WB must hold `WN`/`WD`/`RegWrite`.

## Operation
- **Reset** (`rst_n` low, asynchronous):
  - every register is 0;
  - counter is 0, so `mul_busy` is 0;
  - `pend_valid` is 0, so `wr_stall` is 0.
  - Reset mid-multiply or with a pending entry discards both; the first edge after release behaves as idle.
- **Counter:**
  - `mul_start` while counter is 0 loads `MUL_LAT`.
  - When non-zero, the counter decrements by 1 per edge.
  - `mul_start` while busy is ignored; the count is not restarted.
  - `mul_busy` = (counter != 0).
- **Write is valid** when `RegWrite` and `WN` != 0. Writes to register 0 are ignored and never stall.
- **Write path**, evaluated at each edge with state before the edge:
  - Valid write, `pend_valid`=0, not busy: `array[WN]` <= `WD`.
  - Valid write, `pend_valid`=0, busy: the pending entry captures (`WN`, `WD`) and `pend_valid` <= 1.
  - Valid write with `pend_valid`=1: the write is not accepted and `wr_stall`=1.
  - `pend_valid`=1 and not busy (drain): `array[pend_addr]` <= `pend_data` and `pend_valid` <= 0.
  - One array write per edge at most.
- `wr_stall` = `RegWrite` and (`WN` != 0) and `pend_valid` (combinational).
- **Read priority**, per port, with N = `RN1` or `RN2`:
  1. N == 0 → 0.
  2. `BYPASS` and an accepted valid write with `WN` == N → `WD`.
  3. `BYPASS` and `pend_valid` with `pend_addr` == N → `pend_data`.
  4. Otherwise → `array[N]`.
  - A stalled write is never forwarded.
- Arithmetic: the counter is wide enough to hold `MUL_LAT`; there is no wrap. Data is stored unmodified.

## Timing
- Read latency 0: the output is combinational from `RN`, the array, the pending entry and the WB inputs.
- Write latency: visible in the array 1 edge after acceptance. With `BYPASS`=1 it is also visible on the read port in the acceptance cycle.
- Multiply timing for `mul_start` sampled at edge k:
  - `mul_busy` is high after edge k through edge k+`MUL_LAT`, i.e. high for `MUL_LAT` cycles.
  - The pending drain occurs at edge k+`MUL_LAT`+1.
- `mul_busy` falls at the same edge that the counter reaches 0. A write arriving in the following cycle with `pend_valid`=1 sees `wr_stall`=1 for exactly that one drain cycle.
- A `mul_start` in the drain cycle restarts the counter. The drain still happens at that edge, because busy is evaluated before the edge.

## Test plan
- **Reset and read:** drive `rst_n`=0 mid-operation, then release; read regs 1..31 → all 0, `mul_busy`=0, `wr_stall`=0. Write r0=0xFFFF_FFFF → r0 still reads 0.
- **Idle write with bypass:** write r5=0x1234 and read `RN1`=5 in the same cycle → `RD1`=0x1234 the same cycle (`BYPASS`=1); `BYPASS`=0 → 0 the same cycle and 0x1234 the next.
- **Write during busy:** `MUL_LAT`=4; pulse `mul_start`; one cycle later write r7=0xAA.
  - → `pend_valid`, `RD2`(r7)=0xAA, array unchanged.
  - Drain happens one edge after `mul_busy` falls; r7=0xAA persists afterwards.
- **Stall:** during busy, write r3=1, then present r4=2 → `wr_stall`=1 until the drain cycle inclusive; r4 is accepted the edge after the drain; final r3=1, r4=2.
- **Ignored restart:** `mul_start` while busy → the count is not reloaded; `mul_busy` is high for exactly `MUL_LAT` cycles from the first pulse.
- **Reset during busy with pending:** `rst_n`=0 with counter=2 and pending r9=0x55 → r9=0, `mul_busy`=0, and no drain occurs after release.
